// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: instruction fields and zero flag in, datapath control word out
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
    logic       illegal_instr;

    modport master (
        input  op, funct3, funct7b5, zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal_instr
    );

    modport slave (
        output op, funct3, funct7b5, zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal_instr
    );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: RV32I multicycle FSM control unit; CTRL_ILLEGAL_TRAP_EN adds a sticky ILLEGAL trap state
module multicycle_controller #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input logic                     clk,
    input logic                     rst_n,
    multicycle_controller_if.master bus
);
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_ALUWB    = 4'd7;
    localparam logic [3:0] S_EXECUTEI = 4'd8;
    localparam logic [3:0] S_JAL      = 4'd9;
    localparam logic [3:0] S_BEQ      = 4'd10;
`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam logic [3:0] S_ILLEGAL  = 4'd11;
`endif

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic       w_pcupdate;
    logic       w_branch;
    logic [1:0] w_aluop;
    logic       w_adrsrc;
    logic       w_memwrite;
    logic       w_irwrite;
    logic       w_regwrite;
    logic [1:0] w_resultsrc;
    logic [1:0] w_alusrca;
    logic [1:0] w_alusrcb;
    logic [1:0] w_immsrc;
    logic [2:0] w_aluctrl;
    logic       w_illegal;
    logic       w_quiet;

    // state register; reset returns to FETCH from any state, even mid-instruction
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= RESET_STATE;
        else
            r_state <= w_next;
    end

    // next-state logic; unused encodings fall back to FETCH
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_next = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_RTYPE:          w_next = S_EXECUTER;
                    OP_ITYPE:          w_next = S_EXECUTEI;
                    OP_BRANCH:         w_next = S_BEQ;
                    OP_JAL:            w_next = S_JAL;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    default:           w_next = S_ILLEGAL;
`else
                    default:           w_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   w_next = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_next = S_MEMWB;
            S_EXECUTER: w_next = S_ALUWB;
            S_EXECUTEI: w_next = S_ALUWB;
            S_JAL:      w_next = S_ALUWB;
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_ILLEGAL:  w_next = S_ILLEGAL;
`endif
            default:    w_next = S_FETCH;
        endcase
    end

    // Moore control word per state; anything not set stays 0
    always_comb begin
        w_pcupdate  = 1'b0;
        w_branch    = 1'b0;
        w_aluop     = 2'b00;
        w_adrsrc    = 1'b0;
        w_memwrite  = 1'b0;
        w_irwrite   = 1'b0;
        w_regwrite  = 1'b0;
        w_resultsrc = 2'b00;
        w_alusrca   = 2'b00;
        w_alusrcb   = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_irwrite   = 1'b1;
                w_alusrcb   = 2'b10;
                w_resultsrc = 2'b10;
                w_pcupdate  = 1'b1;
            end
            S_DECODE: begin
                w_alusrca = 2'b01;
                w_alusrcb = 2'b01;
            end
            S_MEMADR: begin
                w_alusrca = 2'b10;
                w_alusrcb = 2'b01;
            end
            S_MEMREAD:  w_adrsrc = 1'b1;
            S_MEMWB: begin
                w_resultsrc = 2'b01;
                w_regwrite  = 1'b1;
            end
            S_MEMWRITE: begin
                w_adrsrc   = 1'b1;
                w_memwrite = 1'b1;
            end
            S_EXECUTER: begin
                w_alusrca = 2'b10;
                w_aluop   = 2'b10;
            end
            S_EXECUTEI: begin
                w_alusrca = 2'b10;
                w_alusrcb = 2'b01;
                w_aluop   = 2'b10;
            end
            S_ALUWB:    w_regwrite = 1'b1;
            S_JAL: begin
                w_alusrca  = 2'b01;
                w_alusrcb  = 2'b10;
                w_pcupdate = 1'b1;
            end
            S_BEQ: begin
                w_alusrca = 2'b10;
                w_branch  = 1'b1;
                w_aluop   = 2'b01;
            end
            default: ;
        endcase
    end

    // ALU operation decode; op[5] separates R-type sub from I-type addi with imm[10] set
    always_comb begin
        w_aluctrl = 3'b000;
        if (w_aluop == 2'b01)
            w_aluctrl = 3'b001;
        else if (w_aluop == 2'b10) begin
            case (bus.funct3)
                3'b000:  w_aluctrl = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
                3'b010:  w_aluctrl = 3'b101;
                3'b110:  w_aluctrl = 3'b011;
                3'b111:  w_aluctrl = 3'b010;
                default: w_aluctrl = 3'b000;
            endcase
        end
    end

    // immediate format decode, purely from the opcode
    always_comb begin
        w_immsrc = (bus.op == OP_STORE)  ? 2'b01 :
                   (bus.op == OP_BRANCH) ? 2'b10 :
                   (bus.op == OP_JAL)    ? 2'b11 : 2'b00;
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign w_illegal = (r_state == S_ILLEGAL);
`else
    assign w_illegal = 1'b0;
`endif

    // reset and the trap state both silence the whole control word
    assign w_quiet = !rst_n | w_illegal;

    assign bus.PCWrite       = !w_quiet & (w_pcupdate | (w_branch & bus.zero));
    assign bus.AdrSrc        = !w_quiet & w_adrsrc;
    assign bus.MemWrite      = !w_quiet & w_memwrite;
    assign bus.IRWrite       = !w_quiet & w_irwrite;
    assign bus.RegWrite      = !w_quiet & w_regwrite;
    assign bus.ResultSrc     = w_quiet ? 2'b00 : w_resultsrc;
    assign bus.ALUSrcA       = w_quiet ? 2'b00 : w_alusrca;
    assign bus.ALUSrcB       = w_quiet ? 2'b00 : w_alusrcb;
    assign bus.ImmSrc        = w_quiet ? 2'b00 : w_immsrc;
    assign bus.ALUControl    = w_quiet ? 3'b000 : w_aluctrl;
    assign bus.illegal_instr = rst_n & w_illegal;
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Control unit for the multicycle RV32I datapath. It drives the datapath ALU and is the producer of the ALU's operation-select and operand-select controls. It also consumes the ALU `zero` flag.
- FSM sequences each instruction through fetch, decode, execute, memory and writeback.
- Emits one control word per state, plus a combinational ALU-operation decode.
- Sits between the instruction register (op/funct fields) and the datapath muxes, enables and ALU.

Parameters:
- RESET_STATE, 4'd0, state entered on reset (FETCH); not to be overridden in the core.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  synchronous reset, active low
- op  in  7  instruction[6:0]
- funct3  in  3  instruction[14:12]
- funct7b5  in  1  instruction[30]
- zero  in  1  ALU zero flag, same-cycle combinational
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address: 0 = PC, 1 = Result
- MemWrite  out  1  data memory write enable
- IRWrite  out  1  instruction/OldPC register enable
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rd1
- ALUSrcB  out  2  00 = rd2, 01 = imm, 10 = const 4
- ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J
- ALUControl  out  3  000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt
- illegal_instr  out  1  only with the optional feature; otherwise tied 0

Behaviour:
- Clock and reset
  - One clock domain.
  - rst_n is sampled on the rising clk edge. rst_n=0 → state ← FETCH on that edge, including mid-instruction.
  - While rst_n=0, all outputs are forced to 0; no write enable may assert.
  - The first cycle after release is FETCH.
- State register: 4 bits. States: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, ALUWB 7, EXECUTEI 8, JAL 9, BEQ 10, ILLEGAL 11 (feature only). Unused encodings → FETCH.
- Transitions
  - FETCH→DECODE.
  - DECODE branches on op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1100011 → BEQ
    - 1101111 → JAL
    - other → FETCH (or ILLEGAL with the feature)
  - MEMADR: op=0000011 → MEMREAD, else MEMWRITE.
  - MEMREAD→MEMWB.
  - EXECUTER→ALUWB; EXECUTEI→ALUWB; JAL→ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BEQ → FETCH.
- Moore outputs per state (unlisted outputs = 0)
  - FETCH: IRWrite=1, ALUSrcB=10, ResultSrc=10, PCUpdate=1, ALUOp=00.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - MEMREAD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: AdrSrc=1, MemWrite=1.
  - EXECUTER: ALUSrcA=10, ALUOp=10.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: RegWrite=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1, ALUOp=00.
  - BEQ: ALUSrcA=10, Branch=1, ALUOp=01.
- PCWrite = PCUpdate | (Branch & zero). This is combinational, so zero is used in the same BEQ cycle.
- ALU decode (combinational, internal ALUOp)
  - ALUOp 00 → 000.
  - ALUOp 01 → 001.
  - ALUOp 10, by funct3:
    - 000 → 001 if (op[5] & funct7b5), else 000
    - 010 → 101
    - 110 → 011
    - 111 → 010
    - any other funct3 → 000
- ImmSrc decode (combinational on op, independent of state)
  - 0100011 → 01
  - 1100011 → 10
  - 1101111 → 11
  - else → 00
- Cycles per instruction: lw 5, sw 4, R-type 4, I-ALU 4, beq 3, jal 4.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - DECODE with an unrecognised op → ILLEGAL.
  - ILLEGAL holds itself until reset, with illegal_instr=1 and every other output 0.
- Undefined:
  - Unrecognised op → FETCH; the instruction behaves as a 2-cycle nop.
  - No ILLEGAL state exists and illegal_instr is constant 0.

Test Plan:
- Reset held 3 cycles mid-MEMREAD, then released → all outputs 0 during reset; the first cycle after release shows FETCH outputs (IRWrite=1, PCWrite=1, ALUSrcB=10).
- lw (op=0000011) → state sequence 0,1,2,3,4; MEMWB has RegWrite=1, ResultSrc=01; exactly 5 cycles before next FETCH.
- R-type sub (op=0110011, funct3=000, funct7b5=1) → ALUControl=001 in EXECUTER; the same with funct7b5=0 → 000; funct3=111 → 010; funct3=110 → 011.
- beq with zero=1 vs zero=0 → PCWrite=1 vs 0 in the BEQ cycle; ALUControl=001; ImmSrc=10; returns to FETCH after 3 cycles.
- sw (op=0100011) → sequence 0,1,2,5; MemWrite=1 only in state 5; ImmSrc=01; RegWrite never asserts.
- op=1111111 → without CTRL_ILLEGAL_TRAP_EN, returns to FETCH after DECODE; with it, illegal_instr=1 and the state stays ILLEGAL for 10+ cycles until rst_n=0.
